// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes and the memory-stage state encoding.
// Imported by the pipeline stages.
package cpu_pkg;

  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;
  localparam logic [5:0] ALU_OP = 6'b000000;
  localparam logic [5:0] ADDI   = 6'b001000;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] BNE    = 6'b000101;

  localparam logic [31:0] NOP = 32'b0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == LW) || (op == SW);
  endfunction

endpackage

// File: rtl/stall_timer.sv
// BUSY-cycle counter for the memory stage.
// expired is high during the TIMEOUT-th enabled cycle after a clear.
module stall_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: passes ALU results through, runs lw/sw on a
// ready-strobed bus with a BUSY timeout.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] result,
  input  logic [31:0] inst_EX,
  input  logic [31:0] wdata,
  output logic        data_stall,
  output logic [31:0] inst_MEM,
  output logic [31:0] wback,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] inst_q;
  logic        we_q;
  logic        is_mem;
  logic        start;
  logic        busy;
  logic        expired;

  assign is_mem = is_mem_op(inst_EX[31:26]);
  assign busy   = (state == BUSY);
  assign start  = (state == IDLE) && is_mem;

  stall_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (start),
    .enable (busy),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (is_mem) state_nxt = BUSY;
      BUSY: if (mem_ready || expired) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_stall = start || (busy && !mem_ready);
    mem_req    = busy;
    mem_we     = busy && we_q;
    bus_err    = busy && expired && !mem_ready;
  end

  // mem_ready wins over a same-cycle timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q    <= NOP;
      we_q      <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      inst_MEM  <= NOP;
      wback     <= 32'd0;
    end else if (!busy) begin
      if (is_mem) begin
        inst_q    <= inst_EX;
        we_q      <= (inst_EX[31:26] == SW);
        mem_addr  <= {result[31:2], 2'b00};
        mem_wdata <= wdata;
        inst_MEM  <= NOP;
        wback     <= 32'd0;
      end else begin
        inst_MEM <= inst_EX;
        wback    <= result;
      end
    end else if (mem_ready) begin
      inst_MEM <= inst_q;
      wback    <= we_q ? mem_addr : mem_rdata;
    end else if (expired) begin
      inst_MEM <= NOP;
      wback    <= 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios
// plus a randomized instruction stream against a reference model.
module tb_mem_access_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] result;
  logic [31:0] inst_EX;
  logic [31:0] wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        st1, req1, we1, err1;
  logic [31:0] im1, wb1, ad1, wd1;
  logic        st4, req4, we4, err4;
  logic [31:0] im4, wb4, ad4, wd4;

  logic        use4;
  logic        ob_stall, ob_req, ob_we, ob_err;
  logic [31:0] ob_inst, ob_wb, ob_addr, ob_wdata;

  int checks;
  int errors;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .result(result),
    .inst_EX(inst_EX), .wdata(wdata),
    .data_stall(st1), .inst_MEM(im1), .wback(wb1),
    .mem_req(req1), .mem_we(we1), .mem_addr(ad1),
    .mem_wdata(wd1), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .bus_err(err1)
  );

  mem_access_stage #(.TIMEOUT(4)) dut4 (
    .clk(clk), .reset(reset), .result(result),
    .inst_EX(inst_EX), .wdata(wdata),
    .data_stall(st4), .inst_MEM(im4), .wback(wb4),
    .mem_req(req4), .mem_we(we4), .mem_addr(ad4),
    .mem_wdata(wd4), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .bus_err(err4)
  );

  assign ob_stall = use4 ? st4 : st1;
  assign ob_req   = use4 ? req4 : req1;
  assign ob_we    = use4 ? we4 : we1;
  assign ob_err   = use4 ? err4 : err1;
  assign ob_inst  = use4 ? im4 : im1;
  assign ob_wb    = use4 ? wb4 : wb1;
  assign ob_addr  = use4 ? ad4 : ad1;
  assign ob_wdata = use4 ? wd4 : wd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] ADD_I  = 32'h0022_1820;
  localparam logic [31:0] ADDI_I = 32'h2022_0005;
  localparam logic [31:0] LW_I   = 32'h8C22_0104;
  localparam logic [31:0] SW_I   = 32'hAC22_0020;

  // Present one lw/sw (ready on BUSY cycle d, never if d<0)
  // and collect what the bus side showed while it ran.
  task automatic do_mem(
    input  logic [31:0] inst, res, wd, rd,
    input  int          d,
    output int          stalls, errs, busy,
    output logic        stable,
    output logic [31:0] addr, wdat,
    output logic        we
  );
    inst_EX   = inst;
    result    = res;
    wdata     = wd;
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    #1;
    stalls = ob_stall ? 1 : 0;
    errs   = ob_err ? 1 : 0;
    busy   = 0;
    stable = 1'b1;
    @(posedge clk); #1;
    addr = ob_addr;
    wdat = ob_wdata;
    we   = ob_we;
    while (ob_req && busy < 300) begin
      mem_ready = (busy == d);
      mem_rdata = (busy == d) ? rd : $urandom;
      #1;
      if (ob_stall) stalls++;
      if (ob_err) errs++;
      if (ob_addr !== addr || ob_wdata !== wdat || ob_we !== we)
        stable = 1'b0;
      @(posedge clk); #1;
      busy++;
    end
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    inst_EX = NOP;
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    use4    = 1'b0;
    reset   = 1'b1;
    inst_EX = LW_I;
    result  = 32'h1234_5678;
    wdata   = 32'h9;
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    #2;
    checks++;
    if ({im1, wb1, ad1, wd1} !== 128'd0) begin
      errors++;
      $display("FAIL reset_regs got %h %h %h %h want 0",
               im1, wb1, ad1, wd1);
    end
    checks++;
    if ({req1, we1, err1} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl got %b want 000",
               {req1, we1, err1});
    end
    checks++;
    if (st1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_lw got %b want 1", st1);
    end
    inst_EX = NOP;
    mem_ready = 1'b0;
    #1;
    reset = 1'b0;
    checks++;
    if (st1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_nop got %b want 0", st1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    int stall_seen;
    stall_seen = 0;
    inst_EX = ADD_I;
    result  = 32'h11;
    #1;
    if (ob_stall) stall_seen++;
    @(posedge clk); #1;
    checks++;
    if (ob_inst !== ADD_I || ob_wb !== 32'h11) begin
      errors++;
      $display("FAIL alu_add got %h/%h want %h/%h",
               ob_inst, ob_wb, ADD_I, 32'h11);
    end
    inst_EX   = ADDI_I;
    result    = 32'h22;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    if (ob_stall) stall_seen++;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    checks++;
    if (ob_inst !== ADDI_I || ob_wb !== 32'h22) begin
      errors++;
      $display("FAIL alu_addi got %h/%h want %h/%h",
               ob_inst, ob_wb, ADDI_I, 32'h22);
    end
    checks++;
    if (stall_seen != 0) begin
      errors++;
      $display("FAIL alu_stall got %0d want 0", stall_seen);
    end
  endtask

  task automatic test_lw();
    int s, e, b;
    logic st, we;
    logic [31:0] a, w;
    do_mem(LW_I, 32'h104, 32'h0, 32'hCAFE_F00D, 0,
           s, e, b, st, a, w, we);
    inst_EX = NOP;
    checks++;
    if (a !== 32'h104 || we !== 1'b0) begin
      errors++;
      $display("FAIL lw_bus got %h/%b want 104/0", a, we);
    end
    checks++;
    if (s != 1 || b != 1) begin
      errors++;
      $display("FAIL lw_timing got stall %0d busy %0d want 1 1",
               s, b);
    end
    checks++;
    if (ob_inst !== LW_I || ob_wb !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL lw_wb got %h/%h want %h/cafef00d",
               ob_inst, ob_wb, LW_I);
    end
  endtask

  task automatic test_sw_delayed();
    int s, e, b;
    logic st, we;
    logic [31:0] a, w;
    do_mem(SW_I, 32'h20, 32'h55, 32'h0BAD_0BAD, 5,
           s, e, b, st, a, w, we);
    inst_EX = NOP;
    checks++;
    if (we !== 1'b1 || w !== 32'h55 || a !== 32'h20 || st !== 1'b1)
    begin
      errors++;
      $display("FAIL sw_bus got we %b wd %h a %h stable %b",
               we, w, a, st);
    end
    checks++;
    if (s != 6 || e != 0) begin
      errors++;
      $display("FAIL sw_stall got %0d err %0d want 6 0", s, e);
    end
    checks++;
    if (ob_inst !== SW_I || ob_wb !== 32'h20) begin
      errors++;
      $display("FAIL sw_wb got %h/%h want %h/20",
               ob_inst, ob_wb, SW_I);
    end
  endtask

  task automatic test_back_to_back();
    int s1, s2, e, b;
    logic st, we;
    logic [31:0] a, w;
    do_mem(LW_I, 32'h1003, 32'h0, 32'h1357_9BDF, 0,
           s1, e, b, st, a, w, we);
    checks++;
    if (ob_inst !== LW_I || ob_wb !== 32'h1357_9BDF || a !== 32'h1000)
    begin
      errors++;
      $display("FAIL b2b_first got %h/%h addr %h",
               ob_inst, ob_wb, a);
    end
    do_mem(SW_I, 32'h2007, 32'h77, 32'h0, 0,
           s2, e, b, st, a, w, we);
    inst_EX = NOP;
    checks++;
    if (ob_inst !== SW_I || ob_wb !== 32'h2004) begin
      errors++;
      $display("FAIL b2b_second got %h/%h want %h/2004",
               ob_inst, ob_wb, SW_I);
    end
    checks++;
    if (s1 + s2 != 2) begin
      errors++;
      $display("FAIL b2b_stalls got %0d want 2", s1 + s2);
    end
  endtask

  task automatic test_ready_tie();
    int s, e, b;
    logic st, we;
    logic [31:0] a, w;
    use4 = 1'b1;
    do_mem(LW_I, 32'h40, 32'h0, 32'hA5A5_5A5A, 3,
           s, e, b, st, a, w, we);
    inst_EX = NOP;
    checks++;
    if (e != 0 || b != 4 || ob_wb !== 32'hA5A5_5A5A) begin
      errors++;
      $display("FAIL tie got err %0d busy %0d wb %h", e, b, ob_wb);
    end
    use4 = 1'b0;
  endtask

  task automatic test_timeout();
    int s, e, b;
    logic st, we;
    logic [31:0] a, w;
    use4 = 1'b1;
    do_mem(LW_I, 32'h80, 32'h0, 32'h0, -1,
           s, e, b, st, a, w, we);
    inst_EX = NOP;
    checks++;
    if (e != 1 || b != 4) begin
      errors++;
      $display("FAIL timeout_err got err %0d busy %0d want 1 4",
               e, b);
    end
    checks++;
    if (ob_inst !== NOP || ob_wb !== 32'd0 || ob_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_out got %h/%h req %b",
               ob_inst, ob_wb, ob_req);
    end
    inst_EX = ADD_I;
    result  = 32'h99;
    @(posedge clk); #1;
    inst_EX = NOP;
    checks++;
    if (ob_inst !== ADD_I || ob_wb !== 32'h99 || ob_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle got %h/%h err %b",
               ob_inst, ob_wb, ob_err);
    end
    use4 = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid_busy();
    int s, e, b, errs_seen;
    logic st, we;
    logic [31:0] a, w;
    errs_seen = 0;
    inst_EX = SW_I;
    result  = 32'h300;
    wdata   = 32'hF0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (err1) errs_seen++;
    inst_EX = NOP;
    reset   = 1'b1;
    #1;
    checks++;
    if ({req1, we1, err1} !== 3'b000) begin
      errors++;
      $display("FAIL rst_busy_ctl got %b want 000",
               {req1, we1, err1});
    end
    checks++;
    if ({im1, wb1, ad1, wd1} !== 128'd0) begin
      errors++;
      $display("FAIL rst_busy_regs got %h %h %h %h want 0",
               im1, wb1, ad1, wd1);
    end
    #1 reset = 1'b0;
    @(posedge clk); #1;
    if (err1) errs_seen++;
    do_mem(LW_I, 32'h10, 32'h0, 32'h600D_CAFE, 1,
           s, e, b, st, a, w, we);
    inst_EX = NOP;
    checks++;
    if (ob_inst !== LW_I || ob_wb !== 32'h600D_CAFE || s != 2
        || e + errs_seen != 0) begin
      errors++;
      $display("FAIL rst_then_lw got %h/%h stall %0d err %0d",
               ob_inst, ob_wb, s, e + errs_seen);
    end
  endtask

  task automatic test_random();
    logic [5:0]  op;
    logic [31:0] inst, res, wd, rd, exp_wb;
    int d, s, e, b;
    logic st, we;
    logic [31:0] a, w;
    for (int n = 0; n < 40; n++) begin
      res = $urandom;
      wd  = $urandom;
      rd  = $urandom;
      case ($urandom_range(0, 2))
        0: op = LW;
        1: op = SW;
        default: begin
          op = 6'($urandom_range(0, 63));
          if (op == LW || op == SW) op = ADDI;
        end
      endcase
      inst = {op, 26'($urandom)} | 32'h1;
      if (op == LW || op == SW) begin
        d = $urandom_range(0, 3);
        do_mem(inst, res, wd, rd, d, s, e, b, st, a, w, we);
        exp_wb = (op == SW) ? (res & ~32'h3) : rd;
        checks++;
        if (ob_inst !== inst || ob_wb !== exp_wb) begin
          errors++;
          $display("FAIL rnd_mem_wb got %h/%h want %h/%h",
                   ob_inst, ob_wb, inst, exp_wb);
        end
        checks++;
        if (s != d + 1 || b != d + 1 || e != 0 || st !== 1'b1
            || a !== (res & ~32'h3) || we !== (op == SW)
            || (op == SW && w !== wd)) begin
          errors++;
          $display("FAIL rnd_mem_bus stall %0d busy %0d a %h w %h we %b want d %0d a %h",
                   s, b, a, w, we, d, res & ~32'h3);
        end
      end else begin
        inst_EX   = inst;
        result    = res;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = rd;
        #1;
        checks++;
        if (ob_stall !== 1'b0 || ob_req !== 1'b0) begin
          errors++;
          $display("FAIL rnd_alu_stall got %b req %b want 0",
                   ob_stall, ob_req);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        checks++;
        if (ob_inst !== inst || ob_wb !== res) begin
          errors++;
          $display("FAIL rnd_alu_wb got %h/%h want %h/%h",
                   ob_inst, ob_wb, inst, res);
        end
      end
    end
    inst_EX = NOP;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu();
    test_lw();
    test_sw_delayed();
    test_back_to_back();
    test_ready_tie();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum BUSY cycles before the stage aborts an access.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port result, input, 32: EX-stage ALU result (effective address for lw/sw, writeback value otherwise).
REQ-005 SHALL have port inst_EX, input, 32: instruction held in EX.
REQ-006 SHALL have port wdata, input, 32: store data, already bypassed.
REQ-007 SHALL have port data_stall, output, 1: freezes PC/IF/ID/EX while high.
REQ-008 SHALL have port inst_MEM, output, 32: instruction retired into MEM/WB.
REQ-009 SHALL have port wback, output, 32: writeback value paired with inst_MEM.
REQ-010 SHALL have ports mem_req, mem_we, output, 1 each: bus request and write enable.
REQ-011 SHALL have ports mem_addr and mem_wdata, output, 32 each: bus address and bus store data.
REQ-012 SHALL have port mem_ready, input, 1: bus completion strobe.
REQ-013 SHALL have port mem_rdata, input, 32: bus load data, valid with mem_ready.
REQ-014 SHALL have port bus_err, output, 1: one-cycle pulse on an access timeout.

Function
REQ-015 SHALL decode opcode inst_EX[31:26] as follows: lw = 100011, sw = 101011; every other opcode, including nop = 32'b0, is a non-memory instruction.
REQ-016 SHALL, for a non-memory instruction in IDLE, register inst_MEM <= inst_EX and wback <= result in one cycle, with data_stall low.
REQ-017 SHALL implement FSM states IDLE and BUSY; on lw/sw in IDLE, capture inst_EX, {result[31:2],2'b00}, and wdata, enter BUSY, and register inst_MEM <= nop.
REQ-018 SHALL compute data_stall = (IDLE and inst_EX is lw/sw) or (BUSY and not mem_ready); this signal is combinational.
REQ-019 SHALL, while in BUSY, hold mem_req high; mem_addr, mem_wdata, and mem_we (1 for sw, 0 for lw) SHALL be driven from captured values and remain stable.
REQ-020 SHALL, on BUSY with mem_ready high, register inst_MEM <= captured inst; wback <= mem_rdata for lw, or the captured address for sw; then return to IDLE.
REQ-021 SHALL give a minimum memory-op latency of 2 cycles (IDLE capture, then BUSY with mem_ready), with no upper bound other than TIMEOUT.
REQ-022 SHALL ignore mem_ready and mem_rdata in IDLE.
REQ-023 SHALL count BUSY cycles in an 8-bit counter cleared on BUSY entry; on reaching TIMEOUT without mem_ready, pulse bus_err, deassert mem_req, set inst_MEM <= nop and wback <= 0, release data_stall, and return to IDLE.
REQ-024 SHALL give mem_ready priority if it arrives in the same cycle the timeout is reached: complete normally, with no bus_err.
REQ-025 SHALL ignore address bits [1:0]; there is no misalignment check.
REQ-026 SHALL hold mem_req, mem_we, and bus_err low in IDLE.

Reset
REQ-027 SHALL, on reset assertion, immediately force: state = IDLE, inst_MEM = 0, wback = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, bus_err = 0, counter = 0; data_stall then follows REQ-018.
REQ-028 SHALL, on reset during BUSY, abandon the access with no completion and no bus_err; the first post-reset instruction SHALL be treated as a fresh IDLE decode.

Structure
REQ-029 SHALL place the opcode constants (lw, sw, ALU_op, addi, beq, bne, nop) and the state encoding in the shared package cpu_pkg.
REQ-030 SHALL implement the BUSY timeout counter as one sub-module, stall_timer (inputs clear/enable; output expired).

Verification
REQ-031 SHALL cover: add then addi with no memory ops -> inst_MEM and wback follow one cycle later; data_stall never high.
REQ-032 SHALL cover: lw with result=0x104, mem_ready on the first BUSY cycle, mem_rdata=0xCAFEF00D -> mem_addr=0x104, data_stall high 1 cycle, wback=0xCAFEF00D in cycle 2.
REQ-033 SHALL cover: sw with result=0x20, wdata=0x55, mem_ready delayed 5 cycles -> mem_we=1, mem_wdata=0x55 stable; data_stall high 6 cycles; wback=0x20.
REQ-034 SHALL cover: TIMEOUT=4, lw with mem_ready never asserted -> bus_err pulses once after 4 BUSY cycles; inst_MEM=0; FSM returns to IDLE.
REQ-035 SHALL cover: reset asserted mid-BUSY -> mem_req drops the same cycle; all outputs zero; no bus_err; a following lw completes normally.
REQ-036 SHALL cover: back-to-back lw then sw, each with 1-cycle ready -> two ordered completions; 2 stall cycles in total.
